// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// FSM encoding and width limits.
package sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sub_state_t;

  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle
// for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  borrow,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output borrow,
    output busy
  );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor cell:
// d = a - b - bin, bout = borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // difference and borrow of one bit position
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor,
// LSB first, one bit per clock.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             bw;
  logic             bo;
  logic [CW-1:0]    cnt;
  logic             d_i;
  logic             bw_next;

  full_sub u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bw),
    .d    (d_i),
    .bout (bw_next)
  );

  // handshake and status decode from the state
  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    bus.busy      = (state != S_IDLE);
    bus.diff      = sd;
    bus.borrow    = bo;
  end

  // FSM, operand/result shifters, borrow and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      bw    <= 1'b0;
      bo    <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sa    <= bus.a;
            sb    <= bus.b;
            bw    <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= {d_i, sd[WIDTH-1:1]};
          bw  <= bw_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            bo    <= bw_next;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
